// File: rtl/shortint_frame_pkg.sv
// Shared types and helpers for the shortint frame receiver.
package shortint_frame_pkg;
  typedef bit [0:1][4:2][3:3] field_t;
  typedef enum logic [1:0] {HUNT, PAYLOAD, TRAILER, HOLD} rx_state_t;

  localparam logic [5:0] SYNC_DEFAULT = 6'b101101;

  function automatic logic hdr_is_sync(logic [15:0] w, logic [5:0] sync = SYNC_DEFAULT);
    return w[15:10] == sync;
  endfunction
endpackage

// File: rtl/shortint_frame_rx.sv
// Hunts for a sync header, assembles header+payload+XOR trailer, holds frame until taken.
module shortint_frame_rx
  import shortint_frame_pkg::*;
#(
  parameter int         NWORDS = 2,
  parameter logic [5:0] SYNC   = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output field_t      out_bits,
  output shortint     out_words [1:NWORDS],
  output logic        out_err,
  output logic [7:0]  drop_cnt
);

  rx_state_t   r_state;
  logic        r_ready;
  logic        r_valid;
  logic        r_err;
  field_t      r_bits;
  shortint     r_words [1:NWORDS];
  logic [15:0] r_chk;
  logic [3:0]  r_idx;
  logic [7:0]  r_drop;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = in_valid && r_ready;
  assign w_out_xfer = r_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_bits  <= '0;
      r_chk   <= '0;
      r_idx   <= 4'd1;
      r_drop  <= '0;
      for (int i = 1; i <= NWORDS; i++) r_words[i] <= '0;
    end else begin
      case (r_state)
        HUNT: if (w_in_xfer) begin
          if (hdr_is_sync(in_data, SYNC)) begin
            r_bits  <= field_t'(in_data[5:0]);
            r_chk   <= in_data;
            r_idx   <= 4'd1;
            r_state <= PAYLOAD;
          end else if (r_drop != 8'hFF) begin
            r_drop <= r_drop + 8'd1;
          end
        end
        // Sync-looking words inside a frame are plain payload; no resync here.
        PAYLOAD: if (w_in_xfer) begin
          r_words[r_idx] <= shortint'(in_data);
          r_chk          <= r_chk ^ in_data;
          if (r_idx == 4'(NWORDS)) r_state <= TRAILER;
          else                     r_idx   <= r_idx + 4'd1;
        end
        TRAILER: if (w_in_xfer) begin
          r_err   <= (in_data != r_chk);
          r_valid <= 1'b1;
          r_ready <= 1'b0;
          r_state <= HOLD;
        end
        HOLD: if (w_out_xfer) begin
          r_valid <= 1'b0;
          r_ready <= 1'b1;
          r_state <= HUNT;
        end
        default: r_state <= HUNT;
      endcase
    end
  end

  assign in_ready  = r_ready;
  assign out_valid = r_valid;
  assign out_err   = r_err;
  assign out_bits  = r_bits;
  assign drop_cnt  = r_drop;
  always_comb for (int i = 1; i <= NWORDS; i++) out_words[i] = r_words[i];

endmodule

// File: tb/tb_shortint_frame_rx.sv
// Directed checks for shortint_frame_rx with NWORDS=2.
module tb_shortint_frame_rx;
  import shortint_frame_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  field_t      out_bits;
  shortint     out_words [1:2];
  logic        out_err;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  shortint_frame_rx #(.NWORDS(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bits(out_bits), .out_words(out_words),
    .out_err(out_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w);
    int n;
    in_valid = 1'b1;
    in_data  = w;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("send_timeout", 16'(in_ready), 16'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] trailer);
    send(16'hB435);
    send(16'h1234);
    send(16'hABCD);
    send(trailer);
  endtask

  task automatic check_frame(input string tag, input logic err);
    chk({tag, "_valid"}, 16'(out_valid), 16'd1);
    chk({tag, "_bits"},  16'(out_bits),  16'h0035);
    chk({tag, "_w1"},    16'(out_words[1]), 16'h1234);
    chk({tag, "_w2"},    16'(out_words[2]), 16'hABCD);
    chk({tag, "_err"},   16'(out_err), 16'(err));
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ready", 16'(in_ready),  16'd1);
    chk("rst_valid", 16'(out_valid), 16'd0);
    chk("rst_err",   16'(out_err),   16'd0);
    chk("rst_bits",  16'(out_bits),  16'd0);
    chk("rst_w1",    16'(out_words[1]), 16'd0);
    chk("rst_w2",    16'(out_words[2]), 16'd0);
    chk("rst_drop",  16'(drop_cnt),  16'd0);

    // Clean frame; out_valid visible right after the trailer edge.
    frame(16'h0DCC);
    check_frame("clean", 1'b0);
    chk("clean_ready_hold", 16'(in_ready), 16'd0);
    tick();
    chk("clean_after_valid", 16'(out_valid), 16'd0);
    chk("clean_after_ready", 16'(in_ready),  16'd1);

    frame(16'h0DCD);
    check_frame("bad", 1'b1);
    tick();

    send(16'h0000);
    send(16'hFFFF);
    send(16'h1234);
    chk("garbage_drop", 16'(drop_cnt), 16'd3);
    frame(16'h0DCC);
    check_frame("garbage", 1'b0);
    chk("garbage_drop_hold", 16'(drop_cnt), 16'd3);
    tick();

    out_ready = 1'b0;
    frame(16'h0DCC);
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", 16'(in_ready),  16'd0);
      chk("bp_valid", 16'(out_valid), 16'd1);
      chk("bp_w1",    16'(out_words[1]), 16'h1234);
      chk("bp_w2",    16'(out_words[2]), 16'hABCD);
      chk("bp_bits",  16'(out_bits),  16'h0035);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_rel_valid", 16'(out_valid), 16'd0);
    chk("bp_rel_ready", 16'(in_ready),  16'd1);

    send(16'hB435);
    send(16'h1234);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_valid", 16'(out_valid), 16'd0);
    chk("midrst_ready", 16'(in_ready),  16'd1);
    chk("midrst_w1",    16'(out_words[1]), 16'd0);
    chk("midrst_drop",  16'(drop_cnt),  16'd0);
    frame(16'h0DCC);
    check_frame("midrst", 1'b0);
    tick();

    for (int i = 0; i < 254; i++) send(16'h0000);
    chk("sat_254", 16'(drop_cnt), 16'd254);
    send(16'h0000);
    chk("sat_255", 16'(drop_cnt), 16'd255);
    for (int i = 0; i < 45; i++) send(16'h0000);
    chk("sat_300", 16'(drop_cnt), 16'd255);
    chk("sat_valid", 16'(out_valid), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/shortint_frame_rx.md
# shortint_frame_rx

Receive end of the packed-word link that carries a 6-bit `bit [0:1][4:2][3:3]` field and a `shortint` payload array. The block consumes a serial stream of 16-bit words under a valid/ready handshake and hunts for a sync header. It reassembles one frame (header, NWORDS payload words, XOR trailer), checks integrity and presents the frame on a held output until the sink accepts it. It sits between the link word source and the frame consumer.

## Interface
- NWORDS, default 2: payload `shortint` words per frame; legal range 1..8.
- SYNC, default 6'b101101: header sync pattern in bits [15:10].
- clk  input  1  sole clock; all logic on its rising edge.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- in_valid  input  1  source has a word.
- in_data  input  16  incoming word.
- in_ready  output  1  block accepts the word this cycle.
- out_valid  output  1  assembled frame available.
- out_ready  input  1  sink takes the frame.
- out_bits  output  6  header field, packed as `bit [0:1][4:2][3:3]`; maps to header[5:0].
- out_words  output  NWORDS×16  payload as unpacked `shortint [1:NWORDS]`; index 1 is the first payload word received.
- out_err  output  1  trailer mismatch for the presented frame; valid only with out_valid.
- drop_cnt  output  8  count of words discarded while hunting; saturates at 255.

## Operation
- Word transfer happens on any cycle where in_valid && in_ready. Frame transfer happens on any cycle where out_valid && out_ready.
- Header format: [15:10]=SYNC, [9:6] reserved and ignored, [5:0]=field.
- State HUNT, in_ready=1:
  - Accepted word with [15:10]==SYNC: latch field, set chk=word, idx=1, go to PAYLOAD.
  - Any other accepted word: drop_cnt += 1, saturating.
- State PAYLOAD, in_ready=1:
  - Accepted word: store to out_words[idx], chk ^= word.
  - After word NWORDS is stored, go to TRAILER.
  - A SYNC-looking word here is treated as payload. There is no resync inside a frame.
- State TRAILER, in_ready=1:
  - Accepted word: out_err = (word != chk). Go to HOLD with out_valid=1.
- State HOLD, in_ready=0:
  - out_valid, out_bits, out_words and out_err stay stable until a frame transfer occurs.
  - On transfer, go to HUNT with out_valid=0.
  - Frames with an error are still presented. The sink decides whether to discard them.
- A frame is accepted on the same cycle as a header arriving in HUNT only via the next cycle; the block has no bypass.
- Reset values:
  - State=HUNT, in_ready=1, out_valid=0, out_err=0, out_bits=0, out_words all 0, drop_cnt=0, chk=0, idx=1.
- Reset mid-frame discards the partial frame. Reset during HOLD drops the held frame without a handshake.
- in_data is ignored when in_valid=0. State and registers hold on idle cycles, including cycles inside a frame.

## Timing
- All outputs are registered. in_ready is a function of the state register only; there is no combinational path from in_valid or out_ready.
- Latency: out_valid rises the cycle after the trailer word is accepted.
- Throughput: a frame takes NWORDS+2 accepted words plus at least 1 HOLD cycle. Best case is NWORDS+3 cycles per frame when out_ready is held high.
- Backpressure: while out_ready=0 in HOLD, in_ready stays 0 indefinitely and no input word is lost.
- drop_cnt updates on the cycle after the discarded word is accepted.

## Structure
- Package `shortint_frame_pkg` holds:
  - `typedef bit [0:1][4:2][3:3] field_t`
  - `typedef enum logic [1:0] {HUNT, PAYLOAD, TRAILER, HOLD} rx_state_t`
  - `localparam SYNC_DEFAULT`
  - function `hdr_is_sync(logic [15:0])`
- Single module. No sub-module: the XOR accumulator and payload store are inline.

## Test plan
- Clean frame, NWORDS=2, out_ready=1: words 0xB435, 0x1234, 0xABCD, 0x0DCC.
  - Response: out_valid 1 cycle after the trailer; out_bits=6'b110101, out_words={0x1234,0xABCD}, out_err=0.
- Same frame with trailer 0x0DCD: same out_bits and out_words, out_err=1.
- Garbage before header: words 0x0000, 0xFFFF, 0x1234, then the clean frame. Response: drop_cnt=3 and the frame is assembled correctly.
- Backpressure: clean frame, out_ready=0 for 10 cycles.
  - Response: in_ready=0 and outputs stable throughout.
  - out_ready=1 produces one transfer; the next cycle shows in_ready=1 and out_valid=0.
- Reset after header and one payload word, then the clean frame. Response: no output from the partial frame; the clean frame is assembled with out_err=0.
- Saturation: 300 non-sync words. Response: drop_cnt stops at 255.
